// File: rtl/ec1_pkg.sv
// Shared opcode encodings, FSM state type and opcode-to-execute-state decode
// for the EC-1 control sequencer.
package ec1_pkg;

  localparam int OPW = 3;

  localparam logic [OPW-1:0] OP_IN   = 3'b011;
  localparam logic [OPW-1:0] OP_OUT  = 3'b100;
  localparam logic [OPW-1:0] OP_DEC  = 3'b101;
  localparam logic [OPW-1:0] OP_JNZ  = 3'b110;
  localparam logic [OPW-1:0] OP_HALT = 3'b111;

  typedef enum logic [3:0] {
    ST_START     = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_EX_IN     = 4'd3,
    ST_EX_OUT    = 4'd4,
    ST_EX_DEC    = 4'd5,
    ST_EX_JNZ    = 4'd6,
    ST_EX_NOP    = 4'd7,
    ST_STEP_WAIT = 4'd8,
    ST_HALTED    = 4'd9
  } state_t;

  // Opcodes 000-010 are all treated as NOP.
  function automatic state_t decode_target(input logic [OPW-1:0] op);
    state_t tgt;
    case (op)
      OP_IN:   tgt = ST_EX_IN;
      OP_OUT:  tgt = ST_EX_OUT;
      OP_DEC:  tgt = ST_EX_DEC;
      OP_JNZ:  tgt = ST_EX_JNZ;
      OP_HALT: tgt = ST_HALTED;
      default: tgt = ST_EX_NOP;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/ec1_sequencer_edge_pulse.sv
// Registered rising-edge detector: rise is high for one cycle, one cycle
// after d goes 0->1. Synchronous active-high reset clears both flops.
module edge_pulse (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      prev <= d;
      rise <= d & ~prev;
    end
  end

endmodule

// File: rtl/ec1_sequencer.sv
// EC-1 fetch/decode/execute sequencer with IN/OUT handshakes, single-step and halt.
// Optional retired-instruction counter enabled by defining SEQ_INSTR_COUNT_EN.
//
// state      | meaning
// -----------+---------------------------------------------------------
// START      | one idle cycle after reset
// FETCH      | IRload+PCload: fetch instruction, advance PC
// DECODE     | branch on ir_op
// EX_IN      | INmux held; waits for in_valid, then Aload+in_ready
// EX_OUT     | OutE held until out_ack is sampled
// EX_DEC     | Aload from decrementer, one cycle
// EX_JNZ     | PCload+JNZmux when A != 0, one cycle
// EX_NOP     | one idle cycle
// STEP_WAIT  | single-step pause until a registered step_go rising edge
// HALTED     | Halt=1, absorbing until reset
module ec1_sequencer
  import ec1_pkg::*;
#(
  parameter int OPW = ec1_pkg::OPW
`ifdef SEQ_INSTR_COUNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] ir_op,
  input  logic           a_nz,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           out_ack,
  input  logic           step_mode,
  input  logic           step_go,
  output logic           IRload,
  output logic           PCload,
  output logic           INmux,
  output logic           Aload,
  output logic           JNZmux,
  output logic           OutE,
  output logic           Halt
`ifdef SEQ_INSTR_COUNT_EN
  ,
  output logic [CNT_W-1:0] instr_cnt
`endif
);

  state_t state, state_nxt, exit_tgt;
  logic   step_rise;

  edge_pulse u_step_edge (
    .clk   (clk),
    .reset (reset),
    .d     (step_go),
    .rise  (step_rise)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_START;
    else       state <= state_nxt;
  end

  // step_mode only matters here, so it is effectively sampled at instruction exit.
  assign exit_tgt = step_mode ? ST_STEP_WAIT : ST_FETCH;

  always_comb begin
    state_nxt = state;
    IRload    = 1'b0;
    PCload    = 1'b0;
    INmux     = 1'b0;
    Aload     = 1'b0;
    JNZmux    = 1'b0;
    OutE      = 1'b0;
    Halt      = 1'b0;
    in_ready  = 1'b0;
    case (state)
      ST_START:  state_nxt = ST_FETCH;
      ST_FETCH: begin
        IRload    = 1'b1;
        PCload    = 1'b1;
        state_nxt = ST_DECODE;
      end
      ST_DECODE: state_nxt = decode_target(ir_op);
      ST_EX_IN: begin
        INmux = 1'b1;
        if (in_valid) begin
          Aload     = 1'b1;
          in_ready  = 1'b1;
          state_nxt = exit_tgt;
        end
      end
      ST_EX_OUT: begin
        OutE = 1'b1;
        if (out_ack) state_nxt = exit_tgt;
      end
      ST_EX_DEC: begin
        Aload     = 1'b1;
        state_nxt = exit_tgt;
      end
      ST_EX_JNZ: begin
        JNZmux    = a_nz;
        PCload    = a_nz;
        state_nxt = exit_tgt;
      end
      ST_EX_NOP: state_nxt = exit_tgt;
      ST_STEP_WAIT: begin
        if (step_rise) state_nxt = ST_FETCH;
      end
      ST_HALTED: Halt = 1'b1;
      default:   state_nxt = ST_START;
    endcase
  end

`ifdef SEQ_INSTR_COUNT_EN
  logic in_exec, cnt_inc;

  assign in_exec = (state == ST_EX_IN)  || (state == ST_EX_OUT) ||
                   (state == ST_EX_DEC) || (state == ST_EX_JNZ) ||
                   (state == ST_EX_NOP);

  // Execute states only change state when the instruction retires.
  assign cnt_inc = (in_exec && (state_nxt != state)) ||
                   ((state_nxt == ST_HALTED) && (state != ST_HALTED));

  always_ff @(posedge clk) begin
    if (reset)        instr_cnt <= '0;
    else if (cnt_inc) instr_cnt <= instr_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_ec1_sequencer.sv
// Directed self-checking bench for ec1_sequencer with a tiny IR/PC memory model.
module tb_ec1_sequencer;
  import ec1_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] ir_op;
  logic       a_nz = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       out_ack = 1'b0;
  logic       step_mode = 1'b0;
  logic       step_go = 1'b0;
  logic       IRload, PCload, INmux, Aload, JNZmux, OutE, Halt;
`ifdef SEQ_INSTR_COUNT_EN
  logic [15:0] instr_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [2:0] prog [0:7];
  int         pc;
  logic [2:0] ir;
  logic [7:0] obs;

  localparam int JMP_TGT = 2;

  always #5 clk = ~clk;

  ec1_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .ir_op     (ir_op),
    .a_nz      (a_nz),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_ack   (out_ack),
    .step_mode (step_mode),
    .step_go   (step_go),
    .IRload    (IRload),
    .PCload    (PCload),
    .INmux     (INmux),
    .Aload     (Aload),
    .JNZmux    (JNZmux),
    .OutE      (OutE),
    .Halt      (Halt)
`ifdef SEQ_INSTR_COUNT_EN
    ,
    .instr_cnt (instr_cnt)
`endif
  );

  assign ir_op = ir;
  assign obs   = {IRload, PCload, INmux, Aload, JNZmux, OutE, Halt, in_ready};

  // Datapath stand-in: IR/PC registers driven by the sequencer strobes.
  always @(posedge clk) begin
    if (reset) begin
      pc <= 0;
      ir <= 3'b000;
    end else begin
      if (IRload) ir <= prog[pc];
      if (PCload) pc <= JNZmux ? JMP_TGT : pc + 1;
    end
  end

  task automatic load_prog(input logic [2:0] p0, input logic [2:0] p1, input logic [2:0] p2);
    for (int i = 0; i < 8; i++) prog[i] = OP_HALT;
    prog[0] = p0;
    prog[1] = p1;
    prog[2] = p2;
  endtask

  // Leaves reset deasserted just after a negedge: the current cycle is START (cycle 0).
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ack = 1'b0; step_go = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    load_prog(OP_DEC, OP_HALT, OP_HALT);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; out_ack = 1'b1; step_go = 1'b1; step_mode = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (obs !== 8'h00) $display("FAIL reset_outputs cyc %0d: got %h expected 00", c, obs);
      else n_pass++;
`ifdef SEQ_INSTR_COUNT_EN
      n_checks++;
      if (instr_cnt !== 16'd0) $display("FAIL reset_cnt cyc %0d: got %0d expected 0", c, instr_cnt);
      else n_pass++;
`endif
    end
    in_valid = 1'b0; out_ack = 1'b0; step_go = 1'b0; step_mode = 1'b0;
  endtask

  task automatic test_dec_halt();
    logic [7:0] exp [0:9];
    exp = '{8'h00, 8'hC0, 8'h00, 8'h10, 8'hC0, 8'h00, 8'h02, 8'h02, 8'h02, 8'h02};
    load_prog(OP_DEC, OP_HALT, OP_HALT);
    a_nz = 1'b1; step_mode = 1'b0;
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      n_checks++;
      if (obs !== exp[c]) $display("FAIL dec_halt cyc %0d: got %h expected %h", c, obs, exp[c]);
      else n_pass++;
    end
`ifdef SEQ_INSTR_COUNT_EN
    n_checks++;
    if (instr_cnt !== 16'd2) $display("FAIL dec_halt_cnt: got %0d expected 2", instr_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_in_wait();
    logic [7:0]  exp [0:11];
    logic [11:0] iv;
    exp = '{8'h00, 8'hC0, 8'h00, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h31, 8'hC0, 8'h00, 8'h02};
    iv  = 12'b0001_0000_0110;
    load_prog(OP_IN, OP_HALT, OP_HALT);
    step_mode = 1'b0;
    apply_reset();
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      in_valid = iv[c];
      #1;
      n_checks++;
      if (obs !== exp[c]) $display("FAIL in_wait cyc %0d: got %h expected %h", c, obs, exp[c]);
      else n_pass++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_out_wait();
    logic [7:0]  exp [0:10];
    logic [10:0] ack;
    exp = '{8'h00, 8'hC0, 8'h00, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'hC0, 8'h00, 8'h02};
    ack = 11'b000_1000_0010;
    load_prog(OP_OUT, OP_HALT, OP_HALT);
    step_mode = 1'b0;
    apply_reset();
    for (int c = 0; c < 11; c++) begin
      if (c > 0) @(negedge clk);
      out_ack = ack[c];
      #1;
      n_checks++;
      if (obs !== exp[c]) $display("FAIL out_wait cyc %0d: got %h expected %h", c, obs, exp[c]);
      else n_pass++;
    end
    out_ack = 1'b0;
`ifdef SEQ_INSTR_COUNT_EN
    n_checks++;
    if (instr_cnt !== 16'd2) $display("FAIL out_cnt: got %0d expected 2", instr_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_jnz();
    logic [7:0] exp_t [0:6];
    logic [7:0] exp_n [0:9];
    exp_t = '{8'h00, 8'hC0, 8'h00, 8'h48, 8'hC0, 8'h00, 8'h02};
    exp_n = '{8'h00, 8'hC0, 8'h00, 8'h00, 8'hC0, 8'h00, 8'h00, 8'hC0, 8'h00, 8'h02};
    load_prog(OP_JNZ, 3'b000, OP_HALT);
    step_mode = 1'b0;
    a_nz = 1'b1;
    apply_reset();
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      n_checks++;
      if (obs !== exp_t[c]) $display("FAIL jnz_taken cyc %0d: got %h expected %h", c, obs, exp_t[c]);
      else n_pass++;
    end
    a_nz = 1'b0;
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      n_checks++;
      if (obs !== exp_n[c]) $display("FAIL jnz_not_taken cyc %0d: got %h expected %h", c, obs, exp_n[c]);
      else n_pass++;
    end
  endtask

  task automatic test_step();
    logic [7:0]  exp [0:23];
    logic [23:0] sg;
    exp = '{8'h00, 8'hC0, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h00, 8'hC0, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00,
            8'h00, 8'h00, 8'h00, 8'h00, 8'hC0, 8'h00, 8'h02, 8'h02};
    sg  = 24'hFCFF82;
    load_prog(OP_DEC, OP_DEC, OP_HALT);
    a_nz = 1'b1; step_mode = 1'b1;
    apply_reset();
    for (int c = 0; c < 24; c++) begin
      if (c > 0) @(negedge clk);
      step_go = sg[c];
      #1;
      n_checks++;
      if (obs !== exp[c]) $display("FAIL step cyc %0d: got %h expected %h", c, obs, exp[c]);
      else n_pass++;
    end
    step_go = 1'b0; step_mode = 1'b0;
`ifdef SEQ_INSTR_COUNT_EN
    n_checks++;
    if (instr_cnt !== 16'd3) $display("FAIL step_cnt: got %0d expected 3", instr_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid_out();
    logic [7:0] exp [0:9];
    logic [9:0] rs;
    exp = '{8'h00, 8'hC0, 8'h00, 8'h04, 8'h04, 8'h04, 8'h00, 8'hC0, 8'h00, 8'h04};
    rs  = 10'b00_0010_0000;
    load_prog(OP_OUT, OP_HALT, OP_HALT);
    step_mode = 1'b0;
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      reset = rs[c];
      #1;
      n_checks++;
      if (obs !== exp[c]) $display("FAIL reset_mid_out cyc %0d: got %h expected %h", c, obs, exp[c]);
      else n_pass++;
`ifdef SEQ_INSTR_COUNT_EN
      if (c == 6) begin
        n_checks++;
        if (instr_cnt !== 16'd0) $display("FAIL reset_mid_out_cnt: got %0d expected 0", instr_cnt);
        else n_pass++;
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_dec_halt();
    test_in_wait();
    test_out_wait();
    test_jnz();
    test_step();
    test_reset_mid_out();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
